// File: rtl/t_ff_bank_counter.sv
// WIDTH-bit toggle bank / modulo up-down counter / parallel load register
// with terminal count, registered wrap pulse and sticky overflow.
module t_ff_bank_counter #(
  parameter int WIDTH     = 8,
  parameter int MODULUS   = 2**WIDTH,
  parameter bit SATURATE  = 1'b0,
  parameter int RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  localparam logic [WIDTH:0] L_MOD =
    (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] L_MAX_X =
    (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] L_MAX =
    WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] L_RST =
    WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_m_tgl;
  logic             w_m_up;
  logic             w_m_dn;
  logic             w_m_ld;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_ld_ext;
  logic             w_at_top;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_oor;
  logic [WIDTH-1:0] w_nxt;
  logic             w_wrap_nxt;

  assign w_m_tgl = (mode == 2'b00);
  assign w_m_up  = (mode == 2'b01);
  assign w_m_dn  = (mode == 2'b10);
  assign w_m_ld  = (mode == 2'b11);

  // Compare in WIDTH+1 bits so MODULUS=2**WIDTH is exact
  assign w_q_ext   = {1'b0, r_q};
  assign w_ld_ext  = {1'b0, load_val};
  assign w_at_top  = (w_q_ext >= L_MAX_X);
  assign w_at_max  = (w_q_ext == L_MAX_X);
  assign w_oor     = (w_q_ext >= L_MOD);
  assign w_at_zero = (r_q == '0);

  always_comb begin
    w_nxt      = r_q;
    w_wrap_nxt = 1'b0;
    unique case (1'b1)
      w_m_tgl: begin
        w_nxt = r_q ^ t;
      end
      w_m_up: begin
        if (!w_at_top) begin
          w_nxt = WIDTH'(w_q_ext + 1'b1);
        end else if (!SATURATE) begin
          w_nxt      = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_nxt      = L_MAX;
          w_wrap_nxt = w_at_max;
        end
      end
      w_m_dn: begin
        if (w_at_zero) begin
          w_nxt      = SATURATE ? '0 : L_MAX;
          w_wrap_nxt = 1'b1;
        end else if (w_oor) begin
          w_nxt = L_MAX;
        end else begin
          w_nxt = r_q - 1'b1;
        end
      end
      w_m_ld: begin
        w_nxt = (w_ld_ext < L_MOD) ? load_val : L_MAX;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q    <= L_RST;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (clear) begin
      r_q    <= L_RST;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (!en) begin
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_nxt;
      r_wrap <= w_wrap_nxt;
      if (w_wrap_nxt) r_ovf <= 1'b1;
    end
  end

  assign q          = r_q;
  assign wrap       = r_wrap;
  assign ovf_sticky = r_ovf;
  assign tc         = (w_m_up & w_at_top)
                    | (w_m_dn & w_at_zero);

endmodule

// File: tb/tb_t_ff_bank_counter.sv
// Bench for t_ff_bank_counter: three instances (mod 10 wrap, mod 10
// saturate, mod 256 wrap) against an integer reference model.
module tb_t_ff_bank_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] t = 8'h00;
  logic [7:0] load_val = 8'h00;

  logic [7:0] q [3];
  logic       tc [3];
  logic       wr [3];
  logic       ov [3];

  int mod_p [3] = '{10, 10, 256};
  int sat_p [3] = '{0, 1, 0};
  int mq [3];
  int mw [3];
  int mo [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  t_ff_bank_counter #(.WIDTH(8), .MODULUS(10),
    .SATURATE(1'b0), .RESET_VAL(0)) u0 (
    .clock(clock), .reset(reset), .en(en),
    .clear(clear), .mode(mode), .t(t),
    .load_val(load_val), .q(q[0]), .tc(tc[0]),
    .wrap(wr[0]), .ovf_sticky(ov[0]));

  t_ff_bank_counter #(.WIDTH(8), .MODULUS(10),
    .SATURATE(1'b1), .RESET_VAL(0)) u1 (
    .clock(clock), .reset(reset), .en(en),
    .clear(clear), .mode(mode), .t(t),
    .load_val(load_val), .q(q[1]), .tc(tc[1]),
    .wrap(wr[1]), .ovf_sticky(ov[1]));

  t_ff_bank_counter #(.WIDTH(8), .MODULUS(256),
    .SATURATE(1'b0), .RESET_VAL(0)) u2 (
    .clock(clock), .reset(reset), .en(en),
    .clear(clear), .mode(mode), .t(t),
    .load_val(load_val), .q(q[2]), .tc(tc[2]),
    .wrap(wr[2]), .ovf_sticky(ov[2]));

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0; mw[i] = 0; mo[i] = 0;
    end
  endfunction

  // One rising edge of the rules, in plain integers
  function automatic void model_step(int i);
    int m, top;
    m   = mod_p[i];
    top = m - 1;
    if (clear) begin
      mq[i] = 0; mw[i] = 0; mo[i] = 0;
    end else if (!en) begin
      mw[i] = 0;
    end else begin
      mw[i] = 0;
      case (mode)
        2'd0: mq[i] = mq[i] ^ int'(t);
        2'd1: begin
          if (mq[i] < top) mq[i] = mq[i] + 1;
          else if (sat_p[i] == 0) begin
            mq[i] = 0; mw[i] = 1;
          end else begin
            mw[i] = (mq[i] == top) ? 1 : 0;
            mq[i] = top;
          end
        end
        2'd2: begin
          if (mq[i] == 0) begin
            mq[i] = (sat_p[i] != 0) ? 0 : top;
            mw[i] = 1;
          end else if (mq[i] <= top) mq[i] = mq[i] - 1;
          else mq[i] = top;
        end
        default:
          mq[i] = (int'(load_val) < m) ? int'(load_val) : top;
      endcase
      if (mw[i] != 0) mo[i] = 1;
    end
  endfunction

  function automatic logic model_tc(int i);
    if (mode == 2'd1) return mq[i] >= mod_p[i] - 1;
    if (mode == 2'd2) return mq[i] == 0;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clock);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    reset = 1'b0; en = 1'b0; mode = 2'b00;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      got = {q[i], tc[i], wr[i], ov[i]};
      n_tests++;
      if (got !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d] got %h exp 000", i, got);
      end
    end
    en = 1'b1; mode = 2'b01;
    tick(); tick(); tick();
    n_tests++;
    if (q[0] !== 8'd3) begin
      n_fail++;
      $display("FAIL reset_precount got %0d exp 3", q[0]);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (q[i] !== 8'd0 || ov[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_async[%0d] got q=%0d ovf=%b exp 0 0",
                 i, q[i], ov[i]);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    en = 1'b0;
  endtask

  task automatic test_toggle();
    logic [7:0] eq [3] = '{8'hA5, 8'h00, 8'h00};
    do_clear();
    en = 1'b1; mode = 2'b00;
    for (int k = 0; k < 3; k++) begin
      t = (k < 2) ? 8'hA5 : 8'h00;
      tick();
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (q[i] !== eq[k] || wr[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL toggle[%0d][%0d] got q=%h w=%b exp %h 0",
                   k, i, q[i], wr[i], eq[k]);
        end
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [7:0] eq [4] = '{8'd8, 8'd9, 8'd0, 8'd1};
    logic ew [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic et [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_clear();
    en = 1'b1; mode = 2'b11; load_val = 8'd7;
    tick();
    mode = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if ({q[0], tc[0], wr[0], ov[0]} !==
          {eq[k], et[k], ew[k], eo[k]}) begin
        n_fail++;
        $display("FAIL up_wrap[%0d] got q=%0d tc=%b w=%b o=%b exp %0d %b %b %b",
                 k, q[0], tc[0], wr[0], ov[0], eq[k], et[k], ew[k], eo[k]);
      end
    end
  endtask

  task automatic test_down_sat();
    logic ew [3] = '{1'b0, 1'b1, 1'b1};
    logic eo [3] = '{1'b0, 1'b1, 1'b1};
    do_clear();
    en = 1'b1; mode = 2'b11; load_val = 8'd1;
    tick();
    mode = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if ({q[1], tc[1], wr[1], ov[1]} !==
          {8'd0, 1'b1, ew[k], eo[k]}) begin
        n_fail++;
        $display("FAIL down_sat[%0d] got q=%0d tc=%b w=%b o=%b exp 0 1 %b %b",
                 k, q[1], tc[1], wr[1], ov[1], ew[k], eo[k]);
      end
    end
  endtask

  task automatic test_load_enable_clear();
    do_clear();
    en = 1'b1; mode = 2'b11; load_val = 8'hC8;
    tick();
    n_tests++;
    if (q[0] !== 8'd9 || q[2] !== 8'hC8) begin
      n_fail++;
      $display("FAIL load_clamp got %0d/%h exp 9/c8", q[0], q[2]);
    end
    en = 1'b0; mode = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (q[0] !== 8'd9 || wr[0] !== 1'b0 || tc[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL en_hold[%0d] got q=%0d w=%b tc=%b exp 9 0 1",
                 k, q[0], wr[0], tc[0]);
      end
    end
    en = 1'b1; mode = 2'b01;
    tick();
    n_tests++;
    if (ov[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set got %b exp 1", ov[0]);
    end
    en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    n_tests++;
    if (q[0] !== 8'd0 || ov[0] !== 1'b0 || wr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear got q=%0d o=%b w=%b exp 0 0 0",
               q[0], ov[0], wr[0]);
    end
  endtask

  task automatic test_out_of_range();
    do_clear();
    en = 1'b1; mode = 2'b00; t = 8'h0F;
    tick();
    mode = 2'b10;
    tick();
    n_tests++;
    if (q[0] !== 8'd9 || wr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_down got q=%0d w=%b exp 9 0", q[0], wr[0]);
    end
    mode = 2'b00; t = 8'h06;
    tick();
    mode = 2'b01;
    tick();
    n_tests++;
    if (q[0] !== 8'd0 || wr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_up_wrap got q=%0d w=%b exp 0 1", q[0], wr[0]);
    end
    n_tests++;
    if (q[1] !== 8'd9 || wr[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_up_sat got q=%0d w=%b exp 9 0", q[1], wr[1]);
    end
  endtask

  task automatic test_random();
    logic [10:0] got, exp;
    do_clear();
    for (int k = 0; k < 400; k++) begin
      clear    = ($urandom_range(0, 39) == 0);
      en       = ($urandom_range(0, 7) != 0);
      mode     = 2'($urandom_range(0, 3));
      t        = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      load_val = ($urandom_range(0, 1) == 0) ?
                 8'($urandom_range(0, 12)) : 8'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        got = {q[i], tc[i], wr[i], ov[i]};
        exp = {8'(mq[i]), model_tc(i), mw[i][0], mo[i][0]};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL random[%0d][%0d] got %h exp %h", k, i, got, exp);
        end
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_up_wrap();
    test_down_sat();
    test_load_enable_clear();
    test_out_of_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/t_ff_bank_counter.md
Name: t_ff_bank_counter

Overview:
- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit register of toggle cells with four run-time modes.
  - Per-bit toggle bank.
  - Modulo up counter.
  - Modulo down counter.
  - Parallel load.
- Adds synchronous clear, a terminal-count flag, a registered wrap pulse and a sticky overflow flag.
- Used as a general counter/toggle primitive in the lab blocks that follow.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- MODULUS, 2**WIDTH, count modulus for up/down modes (2..2**WIDTH).
- SATURATE, 0, 0 = wrap at modulus boundary, 1 = hold at boundary.
- RESET_VAL, 0, value loaded into q on reset and on clear (< MODULUS).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserts immediately when low, releases synchronously to clock).
- en  input  1  operation enable; when 0, q holds (clear still acts).
- clear  input  1  synchronous clear to RESET_VAL; highest priority after reset.
- mode  input  2  00 toggle, 01 count up, 10 count down, 11 load.
- t  input  WIDTH  per-bit toggle mask (mode 00 only).
- load_val  input  WIDTH  parallel load value (mode 11 only).
- q  output  WIDTH  register state.
- tc  output  1  terminal count, combinational from q and mode.
- wrap  output  1  registered one-cycle pulse on boundary crossing or saturation hit.
- ovf_sticky  output  1  set by any wrap event; cleared only by reset or clear.

Behaviour:
- Reset (reset==0, asynchronous):
  - q=RESET_VAL, wrap=0, ovf_sticky=0.
  - Takes effect mid-operation with no clock edge.
  - First update occurs on the first rising edge with reset==1.
- Priority at each rising edge: clear > en==0 (hold) > mode action.
- clear==1: q=RESET_VAL, wrap=0, ovf_sticky=0, regardless of en and mode.
- en==0 and clear==0: q holds, wrap=0, ovf_sticky holds.
- Mode 00, toggle:
  - q <= q ^ t; bitwise, MODULUS ignored.
  - t==0 holds q.
  - wrap=0.
- Mode 01, count up:
  - If q < MODULUS-1: q <= q+1, wrap=0.
  - If q >= MODULUS-1:
    - SATURATE=0: q <= 0, wrap=1, ovf_sticky=1.
    - SATURATE=1: q <= MODULUS-1; wrap=1 and ovf_sticky=1 only if q was already MODULUS-1 (attempted overflow).
  - q >= MODULUS (reachable via toggle) is treated as the boundary.
- Mode 10, count down:
  - If q > 0 and q <= MODULUS-1: q <= q-1, wrap=0.
  - If q == 0:
    - SATURATE=0: q <= MODULUS-1, wrap=1, ovf_sticky=1.
    - SATURATE=1: q holds 0, wrap=1, ovf_sticky=1.
  - If q >= MODULUS: q <= MODULUS-1, wrap=0.
- Mode 11, load:
  - q <= load_val if load_val < MODULUS, else q <= MODULUS-1 (clamp).
  - wrap=0.
- tc:
  - 1 when (mode==01 and q>=MODULUS-1) or (mode==10 and q==0); else 0.
  - Independent of en.
- wrap is registered: high exactly one cycle after the edge that caused the event. Consecutive events give consecutive high cycles.
- Latency: all q updates are visible one clock after the sampling edge. No combinational path from t/load_val/en to q.
- Inputs are sampled on the rising edge; the bench drives them on the falling edge.
- Arithmetic is done in WIDTH+1 bits internally; no truncation artefacts at MODULUS=2**WIDTH.

Test Plan:
- Reset: hold reset=0 for 2 edges, release on a negedge, en=0 -> q=0x00, wrap=0, ovf_sticky=0. Assert reset=0 mid-count -> q=0x00 before the next edge.
- Toggle bank (WIDTH=8): mode=00, en=1, t=0xA5 for 2 cycles -> q=0xA5 then 0x00. Then t=0x00 -> q holds 0x00, wrap=0 throughout.
- Up wrap (MODULUS=10, SATURATE=0): load 7, then mode=01 for 4 cycles:
  - q = 8, 9, 0, 1.
  - tc=1 while q==9.
  - wrap=1 only in the cycle after the 9->0 edge.
  - ovf_sticky=1 thereafter.
- Down saturate (MODULUS=10, SATURATE=1): load 1, mode=10 for 3 cycles:
  - q = 0, 0, 0.
  - wrap=1 on the 2nd and 3rd cycles.
  - ovf_sticky=1.
  - tc=1 while q==0.
- Load clamp / enable / clear:
  - MODULUS=10, load_val=0xC8 -> q=9.
  - en=0 with mode=01 for 3 cycles -> q stays 9, wrap=0.
  - clear=1 with en=0 -> q=RESET_VAL(0), ovf_sticky=0.
- Out-of-range recovery (MODULUS=10):
  - Toggle to q=0x0F, then mode=10 -> q=9, wrap=0.
  - From q=0x0F, mode=01 (SATURATE=0) -> q=0, wrap=1.
